// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer: FSM state encoding,
// default datapath widths and the NOP pattern used to fill empty entries.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 32;

    // addi x0, x0, 0 -- harmless filler so empty storage reads as a NOP in waves
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-memory read port and the decode valid/ready port.
//   master : sequencer side (drives imem_en/imem_addr and the decode payload)
//   slave  : memory + decode side (drives imem_rdata and inst_ready)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] Instruction;
    logic [ADDR_W-1:0]  Add;
    logic               inst_valid;
    logic               inst_ready;

    modport master (
        output imem_en, imem_addr, Instruction, Add, inst_valid,
        input  imem_rdata, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, Instruction, Add, inst_valid,
        output imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {instruction, address} holding buffer. Catches a memory response
// that arrives while the decode output register is stalled.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push_i/pop_i/flush_i  write entry / release entry / discard entry
//   instr_i, addr_i       entry written on push
//   instr_o, addr_o       stored entry
//   full_o                entry valid
// Flush wins over push, push over pop (push and pop never coincide).
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               full_o
);
    logic               full_q,  full_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        if (flush_i || (pop_i && !push_i)) begin
            full_d  = 1'b0;
            instr_d = INSTR_W'(NOP);
            addr_d  = '0;
        end else if (push_i) begin
            full_d  = 1'b1;
            instr_d = instr_i;
            addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= INSTR_W'(NOP);
            addr_q  <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
        end
    end

    assign instr_o = instr_q;
    assign addr_o  = addr_q;
    assign full_o  = full_q;
endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the PC, issues reads to a 1-cycle-latency instruction memory, applies
// branch redirects and hands {Instruction, Add} to decode over valid/ready.
// Ports:
//   clk, Reset       clock, async active-low reset
//   en               fetch enable (0 drains and parks in IDLE)
//   Branch           redirect this cycle to TargetAddress (highest priority)
//   TargetAddress    redirect target
//   bus (master)     imem_en/imem_addr/imem_rdata, Instruction/Add/inst_valid/inst_ready
//   state            FSM state for debug
// Output path: a registered output slot plus a bypass of the memory response,
// so a response into an empty slot is visible the cycle it arrives.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               en,
    input  logic               Branch,
    input  logic [ADDR_W-1:0]  TargetAddress,
    fetch_sequencer_if.master  bus,
    output logic [1:0]         state
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;

    logic               skid_full, skid_full_d;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_addr;
    logic               inst_valid, xfer, issue, skid_push, skid_pop;

    // Head of the output: the register if occupied, otherwise the live response.
    assign inst_valid      = out_valid_q | inflight_q;
    assign xfer            = inst_valid & bus.inst_ready;
    assign bus.inst_valid  = inst_valid;
    assign bus.Instruction = out_valid_q ? out_instr_q :
                             (inflight_q ? bus.imem_rdata : '0);
    assign bus.Add         = out_valid_q ? out_addr_q :
                             (inflight_q ? inflight_addr_q : '0);

    // Issue only if the slot is guaranteed free when the response lands;
    // a stalled bypass still counts as free, which is what the skid absorbs.
    assign issue     = (state_q == ST_RUN) && en && !Branch && (!out_valid_q || xfer);
    assign skid_push = !Branch && inflight_q && out_valid_q && !xfer;
    assign skid_pop  = !Branch && skid_full && out_valid_q && xfer;
    assign skid_full_d = skid_push | (skid_full & ~skid_pop);

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;       // parked on pc when idle: no address toggling
    assign state         = state_q;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk     (clk),
        .rst_n   (Reset),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .flush_i (Branch),
        .instr_i (bus.imem_rdata),
        .addr_i  (inflight_addr_q),
        .instr_o (skid_instr),
        .addr_o  (skid_addr),
        .full_o  (skid_full)
    );

    always_comb begin
        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = inflight_addr_q;
        out_valid_d     = out_valid_q;
        out_instr_d     = out_instr_q;
        out_addr_d      = out_addr_q;

        if (Branch)     pc_d = TargetAddress;
        else if (issue) pc_d = pc_q + ADDR_W'(1);
        if (issue)      inflight_addr_d = pc_q;

        if (Branch) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            if (xfer) begin
                if (skid_full) begin
                    out_instr_d = skid_instr;
                    out_addr_d  = skid_addr;
                end else if (inflight_q) begin
                    out_instr_d = bus.imem_rdata;
                    out_addr_d  = inflight_addr_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end else if (inflight_q && !xfer) begin
            // Bypassed response not taken: park it in the output register.
            out_valid_d = 1'b1;
            out_instr_d = bus.imem_rdata;
            out_addr_d  = inflight_addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (!Branch && en) state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (Branch) begin
                    state_d = en ? ST_FLUSH : ST_IDLE;
                end else begin
                    if (skid_push)     state_d = ST_HOLD;
                    else if (skid_pop) state_d = ST_RUN;
                    if (!en && !inflight_d && !out_valid_d && !skid_full_d)
                        state_d = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = !en ? ST_IDLE : (Branch ? ST_FLUSH : ST_RUN);
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            out_valid_q     <= 1'b0;
            out_instr_q     <= '0;
            out_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            out_valid_q     <= out_valid_d;
            out_instr_q     <= out_instr_d;
            out_addr_q      <= out_addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       Reset;
    logic       en, Branch;
    logic [9:0] TargetAddress;
    logic [1:0] state;

    fetch_sequencer_if #(.ADDR_W(10), .INSTR_W(32)) bus ();

    fetch_sequencer #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'd0)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .en            (en),
        .Branch        (Branch),
        .TargetAddress (TargetAddress),
        .bus           (bus),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hDEAD_0000 | {22'd0, a};
    endfunction

    // Synchronous memory, 1-cycle read latency, address-encoded data.
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       en, br;
        logic [9:0] tgt;
        logic       rdy;
        logic       vld;
        logic [9:0] add;
        logic [1:0] st;
        logic       ien;
        logic [9:0] iaddr;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic b, input logic [9:0] t, input logic r,
                                input logic v, input logic [9:0] a, input logic [1:0] s,
                                input logic ie, input logic [9:0] ia);
        vec_t x;
        x.en = e; x.br = b; x.tgt = t; x.rdy = r; x.vld = v; x.add = a;
        x.st = s; x.ien = ie; x.iaddr = ia;
        return x;
    endfunction

    vec_t tbl[26];

    initial begin
        //            en br tgt     rdy vld add     st ien iaddr
        tbl[0]  = mk(1, 0, 10'h000, 1, 0, 10'h000, 0, 0, 10'h000);
        tbl[1]  = mk(1, 0, 10'h000, 1, 0, 10'h000, 1, 1, 10'h000);
        tbl[2]  = mk(1, 0, 10'h000, 1, 1, 10'h000, 1, 1, 10'h001);
        tbl[3]  = mk(1, 0, 10'h000, 1, 1, 10'h001, 1, 1, 10'h002);
        tbl[4]  = mk(1, 0, 10'h000, 1, 1, 10'h002, 1, 1, 10'h003);
        tbl[5]  = mk(1, 0, 10'h000, 1, 1, 10'h003, 1, 1, 10'h004);
        tbl[6]  = mk(1, 0, 10'h000, 1, 1, 10'h004, 1, 1, 10'h005);
        tbl[7]  = mk(1, 0, 10'h000, 0, 1, 10'h005, 1, 1, 10'h006);  // stall starts
        tbl[8]  = mk(1, 0, 10'h000, 0, 1, 10'h005, 1, 0, 10'h007);  // 6 -> skid
        tbl[9]  = mk(1, 0, 10'h000, 0, 1, 10'h005, 2, 0, 10'h007);  // HOLD
        tbl[10] = mk(1, 0, 10'h000, 1, 1, 10'h005, 2, 0, 10'h007);
        tbl[11] = mk(1, 0, 10'h000, 1, 1, 10'h006, 1, 1, 10'h007);
        tbl[12] = mk(1, 0, 10'h000, 1, 1, 10'h007, 1, 1, 10'h008);
        tbl[13] = mk(1, 0, 10'h000, 0, 1, 10'h008, 1, 1, 10'h009);
        tbl[14] = mk(1, 1, 10'h200, 0, 1, 10'h008, 1, 0, 10'h00A);  // branch while stalled
        tbl[15] = mk(1, 0, 10'h000, 1, 0, 10'h000, 3, 0, 10'h200);  // FLUSH
        tbl[16] = mk(1, 0, 10'h000, 1, 0, 10'h000, 1, 1, 10'h200);
        tbl[17] = mk(1, 0, 10'h000, 1, 1, 10'h200, 1, 1, 10'h201);
        tbl[18] = mk(1, 0, 10'h000, 1, 1, 10'h201, 1, 1, 10'h202);
        tbl[19] = mk(1, 1, 10'h3FE, 1, 1, 10'h202, 1, 0, 10'h203);  // branch to wrap area
        tbl[20] = mk(1, 0, 10'h000, 1, 0, 10'h000, 3, 0, 10'h3FE);
        tbl[21] = mk(1, 0, 10'h000, 1, 0, 10'h000, 1, 1, 10'h3FE);
        tbl[22] = mk(1, 0, 10'h000, 1, 1, 10'h3FE, 1, 1, 10'h3FF);
        tbl[23] = mk(1, 0, 10'h000, 1, 1, 10'h3FF, 1, 1, 10'h000);
        tbl[24] = mk(1, 0, 10'h000, 1, 1, 10'h000, 1, 1, 10'h001);
        tbl[25] = mk(1, 0, 10'h000, 1, 1, 10'h001, 1, 1, 10'h002);

        Reset = 1'b0; en = 1'b0; Branch = 1'b0; TargetAddress = '0;
        bus.inst_ready = 1'b0; bus.imem_rdata = '0;
        #1;
        chk("rst valid", 32'(bus.inst_valid), 32'd0);
        chk("rst instr", bus.Instruction, 32'd0);
        chk("rst add",   32'(bus.Add), 32'd0);
        chk("rst state", 32'(state), 32'd0);
        chk("rst imem_en", 32'(bus.imem_en), 32'd0);
        chk("rst imem_addr", 32'(bus.imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) Reset = 1'b1;
        next_cyc();

        for (int i = 0; i < 26; i++) begin
            en = tbl[i].en; Branch = tbl[i].br; TargetAddress = tbl[i].tgt;
            bus.inst_ready = tbl[i].rdy;
            #3;
            chk($sformatf("c%0d valid", i), 32'(bus.inst_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("c%0d add", i), 32'(bus.Add), 32'(tbl[i].add));
                chk($sformatf("c%0d instr", i), bus.Instruction, mem_word(tbl[i].add));
            end
            chk($sformatf("c%0d state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("c%0d imem_en", i), 32'(bus.imem_en), 32'(tbl[i].ien));
            chk($sformatf("c%0d imem_addr", i), 32'(bus.imem_addr), 32'(tbl[i].iaddr));
            next_cyc();
        end
        Branch = 1'b0;

        // Drain with en=0: in-flight 0x002 delivered, then IDLE.
        en = 1'b0; bus.inst_ready = 1'b1;
        #3;
        chk("drain valid", 32'(bus.inst_valid), 32'd1);
        chk("drain add", 32'(bus.Add), 32'h002);
        chk("drain imem_en", 32'(bus.imem_en), 32'd0);
        next_cyc();
        #3;
        chk("drain state", 32'(state), 32'd0);
        chk("drain idle valid", 32'(bus.inst_valid), 32'd0);
        chk("drain idle imem_en", 32'(bus.imem_en), 32'd0);
        chk("drain idle imem_addr", 32'(bus.imem_addr), 32'h003);
        next_cyc();

        // Restart, stall with the skid filled, then reset between edges.
        en = 1'b1; bus.inst_ready = 1'b0;
        next_cyc();
        #3;
        chk("restart state", 32'(state), 32'd1);
        chk("restart imem_addr", 32'(bus.imem_addr), 32'h003);
        next_cyc();
        #3;
        chk("restart add", 32'(bus.Add), 32'h003);
        next_cyc();
        #2;
        chk("pre-rst valid", 32'(bus.inst_valid), 32'd1);
        chk("pre-rst state", 32'(state), 32'd2 - 32'd1);
        Reset = 1'b0;
        #1;
        chk("mid-rst valid", 32'(bus.inst_valid), 32'd0);
        chk("mid-rst instr", bus.Instruction, 32'd0);
        chk("mid-rst add", 32'(bus.Add), 32'd0);
        chk("mid-rst state", 32'(state), 32'd0);
        chk("mid-rst imem_en", 32'(bus.imem_en), 32'd0);
        chk("mid-rst imem_addr", 32'(bus.imem_addr), 32'd0);
        en = 1'b0; bus.inst_ready = 1'b1;
        @(negedge clk) Reset = 1'b1;
        next_cyc();

        // Branch in IDLE: pc moves, state stays IDLE; next run starts at target.
        Branch = 1'b1; TargetAddress = 10'h155;
        #3;
        chk("idle br imem_en", 32'(bus.imem_en), 32'd0);
        next_cyc();
        Branch = 1'b0; en = 1'b1;
        #3;
        chk("idle br state", 32'(state), 32'd0);
        chk("idle br pc", 32'(bus.imem_addr), 32'h155);
        next_cyc();
        #3;
        chk("idle br run", 32'(state), 32'd1);
        chk("idle br issue", 32'(bus.imem_en), 32'd1);
        next_cyc();
        #3;
        chk("idle br valid", 32'(bus.inst_valid), 32'd1);
        chk("idle br add", 32'(bus.Add), 32'h155);
        chk("idle br instr", bus.Instruction, mem_word(10'h155));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the instruction-fetch datapath. It owns the program counter and drives the synchronous instruction memory, which has 1-cycle read latency. It applies branch redirects, and presents fetched instruction/address pairs to decode over a valid/ready handshake, with a one-entry skid buffer absorbing decode back-pressure. It sits between the branch-resolution logic and the decode stage, replacing free-running PC stepping.

Parameters:
ADDR_W, 10, instruction address width (word addressed)
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
en  in  1  fetch enable; 0 parks the sequencer in IDLE
Branch  in  1  branch taken, redirect this cycle
TargetAddress  in  ADDR_W  redirect target
imem_en  out  1  memory read strobe
imem_addr  out  ADDR_W  memory read address
imem_rdata  in  INSTR_W  read data, valid the cycle after imem_en
Instruction  out  INSTR_W  fetched instruction to decode
Add  out  ADDR_W  address of Instruction
inst_valid  out  1  Instruction/Add valid
inst_ready  in  1  decode accepts
state  out  2  FSM state, debug

Behaviour:
- Reset (async, Reset=0):
  - pc=RESET_PC, state=IDLE.
  - inflight=0, skid empty.
  - inst_valid=0, Instruction=0, Add=0, imem_en=0, imem_addr=RESET_PC.
- States: IDLE=0, RUN=1, HOLD=2, FLUSH=3.
- Transfer: occurs when inst_valid and inst_ready are both 1. Instruction/Add stay stable while inst_valid=1 and inst_ready=0.
- Issue condition in RUN: imem_en=1 with imem_addr=pc when Branch=0 and the output slot will be free next cycle.
  - Free means no valid output, or the output transfers this cycle.
  - On issue: pc<=pc+1, wrapping 2^ADDR_W-1 -> 0. The issued address is tagged in inflight_addr.
- Response (cycle after issue):
  - If the output register is empty, imem_rdata/inflight_addr load into the output register, so inst_valid=1 that cycle via a registered-bypass mux.
  - If the output register is stalled, the response goes into the skid buffer and state becomes HOLD.
- HOLD:
  - imem_en=0.
  - On transfer, the skid entry moves to the output register and state returns to RUN.
  - Issue resumes the cycle after the skid drains.
- Throughput: 1 instruction/cycle with inst_ready held at 1. First inst_valid comes 2 cycles after en rises in IDLE.
- Branch=1 in RUN/HOLD/FLUSH (highest priority, beats back-pressure):
  - That cycle: imem_en=0, pc<=TargetAddress.
  - In-flight response, skid and output register are discarded. A transfer coinciding with Branch still counts as accepted.
  - Next cycle: state=FLUSH, inst_valid=0.
  - Following cycle: RUN issues TargetAddress.
  - TargetAddress appears on Add with inst_valid=1 exactly 3 cycles after the Branch cycle.
- Branch in FLUSH: restarts the flush with the new target.
- Branch in IDLE: pc<=TargetAddress, stays IDLE.
- en=0 in RUN/HOLD:
  - Stop issuing.
  - Drain the in-flight response and skid normally.
  - Enter IDLE once inflight=0, skid empty and the output register has transferred.
  - Branch while draining discards the remaining entries and enters IDLE directly.
- Reset mid-operation: all state is lost immediately; no partial transfer is reported.
- imem_addr when imem_en=0: holds pc, so no spurious address toggling.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE/RUN/HOLD/FLUSH)
  - ADDR_W/INSTR_W defaults
  - NOP constant 32'h00000013 for debug fill
- One sub-module fetch_skid_buf: one-entry {instr, addr} buffer with push/pop/flush and full flag.

Test Plan:
- Reset, en=1, inst_ready=1, mem returns addr-encoded data -> inst_valid first at cycle 2; Add=0,1,2,3… on consecutive cycles, no gaps.
- inst_ready=0 for 3 cycles at Add=5 -> Add=5 held stable; skid holds 6; state=HOLD. Ready=1 -> 5,6,7 delivered, none dropped or duplicated.
- Branch=1, TargetAddress=0x200 while Add=8 is stalled -> 8 and in-flight 9 discarded, FLUSH seen. Add=0x200 valid 3 cycles later, then 0x201.
- pc at 0x3FE, free-running -> Add sequence 0x3FE, 0x3FF, 0x000.
- en=0 with one in flight and inst_ready=1 -> last instruction delivered, then state=IDLE, imem_en=0.
- Reset asserted while inst_valid=1 -> outputs 0, state IDLE immediately, without a clock edge.
